// File: rtl/led_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : led_serial_tx
// Purpose  : Multi-lane serial LED transmitter; shifts one RGB word per lane
//            in parallel on a generated clock, then strobes a latch.
// Revision : 1.0  initial release
// ============================================================================
module led_serial_tx #(
   parameter int CH      = 8,
   parameter int CW      = 4,
   parameter int DIV     = 4,
   parameter int LAT_CYC = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             start,
   input  logic             msb_first,
   input  logic [CH*CW-1:0] mean_r,
   input  logic [CH*CW-1:0] mean_g,
   input  logic [CH*CW-1:0] mean_b,
   output logic             cko_o,
   output logic [CH-1:0]    sdo,
   output logic             lat_o,
   output logic             busy,
   output logic             done
);

   localparam int FW = 3 * CW;
   localparam int PW = $clog2(2 * DIV);
   localparam int BW = $clog2(FW);
   localparam int LW = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

   localparam logic [PW-1:0] PH_LAST  = PW'(2 * DIV - 1);
   localparam logic [PW-1:0] PH_HI    = PW'(DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(LAT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   state_t          r_state,   w_state;
   logic [PW-1:0]   r_phase,   w_phase;
   logic [BW-1:0]   r_bit,     w_bit;
   logic [LW-1:0]   r_lat_cnt, w_lat_cnt;
   logic [FW-1:0]   r_shadow [CH];
   logic [FW-1:0]   w_shadow [CH];
   logic            r_msb,     w_msb;
   logic            r_pend,    w_pend;
   logic            r_done,    w_done;
   logic            r_cko,     w_cko;
   logic [CH-1:0]   r_sdo,     w_sdo;
   logic            r_lat,     w_lat;
   logic            r_busy,    w_busy;
   logic            w_capture;
   logic [BW-1:0]   w_k;

   always_comb begin
      w_state   = r_state;
      w_phase   = r_phase;
      w_bit     = r_bit;
      w_lat_cnt = r_lat_cnt;
      w_shadow  = r_shadow;
      w_msb     = r_msb;
      w_pend    = r_pend;
      w_done    = 1'b0;
      w_capture = 1'b0;

      // Dropping enable aborts silently from any state.
      if (!en) begin
         w_state = ST_IDLE;
         w_pend  = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_capture = start;
            end
            ST_SHIFT: begin
               if (start)
                  w_pend = 1'b1;
               if (r_phase == PH_LAST) begin
                  w_phase = '0;
                  if (r_bit == BIT_LAST) begin
                     w_state   = ST_LATCH;
                     w_bit     = '0;
                     w_lat_cnt = '0;
                  end else begin
                     w_bit = r_bit + BW'(1);
                  end
               end else begin
                  w_phase = r_phase + PW'(1);
               end
            end
            ST_LATCH: begin
               if (r_lat_cnt == LAT_LAST) begin
                  // Frame completes; a queued or fresh request chains straight on.
                  w_state   = ST_IDLE;
                  w_done    = 1'b1;
                  w_pend    = 1'b0;
                  w_capture = r_pend | start;
               end else begin
                  if (start)
                     w_pend = 1'b1;
                  w_lat_cnt = r_lat_cnt + LW'(1);
               end
            end
            default: begin
               w_state = ST_IDLE;
            end
         endcase
      end

      if (w_capture) begin
         w_state = ST_SHIFT;
         w_phase = '0;
         w_bit   = '0;
         w_msb   = msb_first;
         w_pend  = 1'b0;
         for (int i = 0; i < CH; i++)
            w_shadow[i] = {mean_r[i*CW +: CW], mean_g[i*CW +: CW], mean_b[i*CW +: CW]};
      end

      // Outputs are decoded from next-state values so they register with the state.
      w_k   = w_msb ? (BIT_LAST - w_bit) : w_bit;
      w_sdo = '0;
      if (w_state == ST_SHIFT)
         for (int i = 0; i < CH; i++)
            w_sdo[i] = w_shadow[i][w_k];
      w_cko  = (w_state == ST_SHIFT) && (w_phase >= PH_HI);
      w_lat  = (w_state == ST_LATCH);
      w_busy = (w_state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_phase   <= '0;
         r_bit     <= '0;
         r_lat_cnt <= '0;
         r_shadow  <= '{default: '0};
         r_msb     <= 1'b0;
         r_pend    <= 1'b0;
         r_done    <= 1'b0;
         r_cko     <= 1'b0;
         r_sdo     <= '0;
         r_lat     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_phase   <= w_phase;
         r_bit     <= w_bit;
         r_lat_cnt <= w_lat_cnt;
         r_shadow  <= w_shadow;
         r_msb     <= w_msb;
         r_pend    <= w_pend;
         r_done    <= w_done;
         r_cko     <= w_cko;
         r_sdo     <= w_sdo;
         r_lat     <= w_lat;
         r_busy    <= w_busy;
      end
   end

   assign cko_o = r_cko;
   assign sdo   = r_sdo;
   assign lat_o = r_lat;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_serial_tx
// Purpose  : Scoreboard bench for led_serial_tx, 8-lane and 1-lane corner.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_serial_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, en;
   logic        start_a, msb_a;
   logic [31:0] r_a, g_a, b_a;
   logic        cko_a, lat_a, busy_a, done_a;
   logic [7:0]  sdo_a;
   logic        start_b, msb_b;
   logic [0:0]  r_b, g_b, b_b;
   logic        cko_b, lat_b, busy_b, done_b;
   logic [0:0]  sdo_b;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nchk = 0;
   int nerr = 0;
   bit mon_en = 1'b0;

   logic [11:0] wa [8];
   logic [7:0]  q_sdo_a [$];
   int          q_busy_a [$], q_lat_a [$], q_done_a [$];
   logic [0:0]  q_sdo_b [$];
   int          q_busy_b [$], q_lat_b [$], q_done_b [$];

   led_serial_tx #(.CH(8), .CW(4), .DIV(2), .LAT_CYC(4)) u_dut_a (
      .clk(clk), .rstn(rstn), .en(en), .start(start_a), .msb_first(msb_a),
      .mean_r(r_a), .mean_g(g_a), .mean_b(b_a),
      .cko_o(cko_a), .sdo(sdo_a), .lat_o(lat_a), .busy(busy_a), .done(done_a)
   );

   led_serial_tx #(.CH(1), .CW(1), .DIV(1), .LAT_CYC(4)) u_dut_b (
      .clk(clk), .rstn(rstn), .en(en), .start(start_b), .msb_first(msb_b),
      .mean_r(r_b), .mean_g(g_b), .mean_b(b_b),
      .cko_o(cko_b), .sdo(sdo_b), .lat_o(lat_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_a();
      for (int i = 0; i < 8; i++) begin
         r_a[i*4 +: 4] = wa[i][11:8];
         g_a[i*4 +: 4] = wa[i][7:4];
         b_a[i*4 +: 4] = wa[i][3:0];
      end
   endtask

   task automatic push_bits_a(input bit msb, input int n);
      for (int b = 0; b < n; b++) begin
         logic [7:0] v;
         int k;
         k = msb ? 11 - b : b;
         for (int i = 0; i < 8; i++) v[i] = wa[i][k];
         q_sdo_a.push_back(v);
      end
   endtask

   task automatic go_a(output int t);
      start_a = 1'b1;
      step(1);
      start_a = 1'b0;
      t = cyc;
   endtask

   task automatic go_b(output int t);
      start_b = 1'b1;
      step(1);
      start_b = 1'b0;
      t = cyc;
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_a"}, int'({cko_a, lat_a, busy_a, done_a, sdo_a}), 0);
      chk({name, "_b"}, int'({cko_b, lat_b, busy_b, done_b, sdo_b}), 0);
   endtask

   // Monitor for the 8-lane instance
   int   blen_a = 0, llen_a = 0;
   logic pcko_a = 1'b0, pbusy_a = 1'b0, plat_a = 1'b0;
   always @(negedge clk) if (mon_en) begin
      if (cko_a && !pcko_a) begin
         chk("a_rise_expected", int'(q_sdo_a.size() != 0), 1);
         if (q_sdo_a.size() != 0) chk("a_sdo", int'(sdo_a), int'(q_sdo_a.pop_front()));
      end
      if (busy_a) blen_a++;
      else if (pbusy_a) begin
         chk("a_busy_fall_expected", int'(q_busy_a.size() != 0), 1);
         if (q_busy_a.size() != 0) chk("a_busy_len", blen_a, q_busy_a.pop_front());
         blen_a = 0;
      end
      if (lat_a) llen_a++;
      else if (plat_a) begin
         chk("a_lat_fall_expected", int'(q_lat_a.size() != 0), 1);
         if (q_lat_a.size() != 0) chk("a_lat_len", llen_a, q_lat_a.pop_front());
         llen_a = 0;
      end
      if (done_a) begin
         chk("a_done_expected", int'(q_done_a.size() != 0), 1);
         if (q_done_a.size() != 0) chk("a_done_cycle", cyc, q_done_a.pop_front());
      end
      pcko_a  = cko_a;
      pbusy_a = busy_a;
      plat_a  = lat_a;
   end

   // Monitor for the 1-lane corner instance
   int   blen_b = 0, llen_b = 0;
   logic pcko_b = 1'b0, pbusy_b = 1'b0, plat_b = 1'b0;
   always @(negedge clk) if (mon_en) begin
      if (cko_b && !pcko_b) begin
         chk("b_rise_expected", int'(q_sdo_b.size() != 0), 1);
         if (q_sdo_b.size() != 0) chk("b_sdo", int'(sdo_b), int'(q_sdo_b.pop_front()));
      end
      if (busy_b) blen_b++;
      else if (pbusy_b) begin
         chk("b_busy_fall_expected", int'(q_busy_b.size() != 0), 1);
         if (q_busy_b.size() != 0) chk("b_busy_len", blen_b, q_busy_b.pop_front());
         blen_b = 0;
      end
      if (lat_b) llen_b++;
      else if (plat_b) begin
         chk("b_lat_fall_expected", int'(q_lat_b.size() != 0), 1);
         if (q_lat_b.size() != 0) chk("b_lat_len", llen_b, q_lat_b.pop_front());
         llen_b = 0;
      end
      if (done_b) begin
         chk("b_done_expected", int'(q_done_b.size() != 0), 1);
         if (q_done_b.size() != 0) chk("b_done_cycle", cyc, q_done_b.pop_front());
      end
      pcko_b  = cko_b;
      pbusy_b = busy_b;
      plat_b  = lat_b;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rstn = 1'b0; en = 1'b1;
      start_a = 1'b1; start_b = 1'b1; msb_a = 1'b1; msb_b = 1'b1;
      r_a = '0; g_a = '0; b_a = '0; r_b = '0; g_b = '0; b_b = '0;
      step(3);
      chk_idle("reset_idle");
      rstn = 1'b1; start_a = 1'b0; start_b = 1'b0;
      step(2);
      chk_idle("post_reset_idle");
      mon_en = 1'b1;

      // Frame, MSB first: lane0 0x1F7, lane7 0x813
      wa = '{12'h1F7, 12'hFFF, 12'h000, 12'hA5C, 12'h3C1, 12'h5A5, 12'h0F0, 12'h813};
      apply_a();
      msb_a = 1'b1;
      push_bits_a(1'b1, 12);
      go_a(t);
      chk("a_start_latency", int'({busy_a, cko_a, sdo_a[0], sdo_a[7]}), 4'b1001);
      q_busy_a.push_back(52); q_lat_a.push_back(4); q_done_a.push_back(t + 52);
      to_cyc(t + 60);

      // Same words, LSB first
      msb_a = 1'b0;
      push_bits_a(1'b0, 12);
      go_a(t);
      q_busy_a.push_back(52); q_lat_a.push_back(4); q_done_a.push_back(t + 52);
      to_cyc(t + 60);

      // Two starts mid-frame with new inputs: one chained frame, no gap
      msb_a = 1'b1;
      push_bits_a(1'b1, 12);
      go_a(t);
      q_busy_a.push_back(104);
      q_lat_a.push_back(4); q_lat_a.push_back(4);
      q_done_a.push_back(t + 52); q_done_a.push_back(t + 104);
      to_cyc(t + 10);
      start_a = 1'b1; step(1); start_a = 1'b0;
      wa = '{12'h6E2, 12'h00F, 12'hF00, 12'h924, 12'h3A9, 12'hC33, 12'h781, 12'h1E4};
      push_bits_a(1'b0, 12);
      to_cyc(t + 20);
      apply_a(); msb_a = 1'b0;
      start_a = 1'b1; step(1); start_a = 1'b0;
      to_cyc(t + 115);

      // Abort during bit 5
      wa = '{12'h1F7, 12'hFFF, 12'h000, 12'hA5C, 12'h3C1, 12'h5A5, 12'h0F0, 12'h813};
      apply_a(); msb_a = 1'b1;
      push_bits_a(1'b1, 5);
      go_a(t);
      q_busy_a.push_back(21);
      to_cyc(t + 20);
      en = 1'b0;
      step(1);
      chk("abort_idle", int'({cko_a, lat_a, busy_a, done_a, sdo_a}), 0);
      start_a = 1'b1; step(1); start_a = 1'b0;
      step(10);
      chk("en0_start_ignored", int'(busy_a), 0);
      en = 1'b1;
      step(2);
      push_bits_a(1'b1, 12);
      go_a(t);
      q_busy_a.push_back(52); q_lat_a.push_back(4); q_done_a.push_back(t + 52);
      to_cyc(t + 60);

      // Reset during LATCH with a queued start
      push_bits_a(1'b1, 12);
      go_a(t);
      q_busy_a.push_back(50); q_lat_a.push_back(2);
      to_cyc(t + 10);
      start_a = 1'b1; step(1); start_a = 1'b0;
      to_cyc(t + 49);
      rstn = 1'b0;
      step(1);
      rstn = 1'b1;
      chk("latch_reset_idle", int'({cko_a, lat_a, busy_a, done_a, sdo_a}), 0);
      step(100);
      chk("pend_cleared_by_reset", int'(busy_a), 0);

      // Corner: DIV=1, CW=1, CH=1; MSB first is R,G,B
      r_b = 1'b1; g_b = 1'b0; b_b = 1'b1; msb_b = 1'b1;
      q_sdo_b.push_back(1'b1); q_sdo_b.push_back(1'b0); q_sdo_b.push_back(1'b1);
      go_b(t);
      q_busy_b.push_back(10); q_lat_b.push_back(4); q_done_b.push_back(t + 10);
      for (int j = 0; j < 6; j++) begin
         chk("b_cko_toggle", int'(cko_b), j % 2);
         step(1);
      end
      to_cyc(t + 15);

      r_b = 1'b1; g_b = 1'b1; b_b = 1'b0; msb_b = 1'b0;
      q_sdo_b.push_back(1'b0); q_sdo_b.push_back(1'b1); q_sdo_b.push_back(1'b1);
      go_b(t);
      q_busy_b.push_back(10); q_lat_b.push_back(4); q_done_b.push_back(t + 10);
      to_cyc(t + 15);

      step(5);
      chk("a_sdo_queue_drained",  q_sdo_a.size(),  0);
      chk("a_busy_queue_drained", q_busy_a.size(), 0);
      chk("a_lat_queue_drained",  q_lat_a.size(),  0);
      chk("a_done_queue_drained", q_done_a.size(), 0);
      chk("b_sdo_queue_drained",  q_sdo_b.size(),  0);
      chk("b_busy_queue_drained", q_busy_b.size(), 0);
      chk("b_lat_queue_drained",  q_lat_b.size(),  0);
      chk("b_done_queue_drained", q_done_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/led_serial_tx.md
# led_serial_tx

Parametrised multi-lane serial LED transmitter. It is the next generation of the LED control path's output stage: it captures one RGB word per lane and shifts all lanes out in parallel on a generated serial clock, then issues a latch pulse. Everything runs on a single clock, with no FIFO and no clock crossing. Lane count, colour depth, bit rate, latch length and bit order are all configurable, and it adds start queuing and abort.

## Interface
- CH, default 8: number of output lanes (≥1).
- CW, default 4: bits per colour component (≥1). Frame word width FW = 3*CW.
- DIV, default 4: clk cycles per cko half-period (≥1). One bit period = 2*DIV cycles.
- LAT_CYC, default 4: latch pulse length in clk cycles (≥1).

- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  level enable. 0 aborts any frame and blocks starts.
- start  in  1  frame request, sampled every cycle.
- msb_first  in  1  bit order, captured at frame start. 1 = MSB first.
- mean_r  in  CH*CW  red per lane. Lane i is at [i*CW +: CW].
- mean_g  in  CH*CW  green, same packing.
- mean_b  in  CH*CW  blue, same packing.
- cko_o  out  1  serial shift clock.
- sdo  out  CH  serial data, one bit per lane.
- lat_o  out  1  latch strobe.
- busy  out  1  frame in progress (SHIFT or LATCH).
- done  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Lane word W_i = {mean_r_i, mean_g_i, mean_b_i}, FW bits. The word is captured into a shadow register in the cycle a frame begins. Inputs may change freely afterwards.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE → SHIFT when start=1 and en=1. The FSM captures the shadow words and msb_first, and clears the bit counter and phase counter.
- SHIFT:
  - The phase counter runs 0..2*DIV-1.
  - cko_o=0 for phases 0..DIV-1 and 1 for phases DIV..2*DIV-1.
  - sdo[i] holds bit k of W_i for the whole bit period. k = FW-1-b when msb_first=1, else k = b, where b is the bit counter 0..FW-1.
  - After phase 2*DIV-1 of bit FW-1, the FSM moves to LATCH.
- LATCH: lat_o=1, cko_o=0, sdo=0 for LAT_CYC cycles. On the last LATCH cycle the next state is IDLE, and done is asserted in the following cycle (the first IDLE or new-SHIFT cycle).
- Pending request:
  - start=1 while busy=1 sets a one-deep pend flag. Multiple starts collapse into one.
  - In the cycle after LATCH ends, if pend=1 or start=1, and en=1, the FSM enters SHIFT directly with no idle cycle. It captures inputs present in that cycle and clears pend.
  - done is still pulsed in that cycle.
- Abort: en=0 in SHIFT or LATCH → next cycle IDLE. All outputs return to idle values, pend is cleared, and done is not pulsed.
- start with en=0 is ignored and does not set pend.
- Counter widths are $clog2 of their ranges. There is no arithmetic on colour data.

## Timing
- Reset (rstn=0 at a clk edge): state IDLE, pend=0. cko_o, sdo, lat_o, busy and done are all 0. Reset mid-frame applies the same way and takes priority over everything.
- All outputs are registered.
- start sampled high at edge t → at t+1: busy=1, sdo holds the first bit, cko_o=0.
- cko_o rises at phase DIV of each bit period. The receiver samples sdo on that rising edge. sdo changes only at phase 0, while cko_o=0.
- Frame length: busy is high for FW*2*DIV + LAT_CYC cycles. done follows in the next cycle, and busy falls in that cycle unless a pending frame starts.
- Idle values: cko_o=0, sdo=0, lat_o=0, busy=0.

## Test plan
- Single frame, CH=8 CW=4 DIV=2 LAT_CYC=4, msb_first=1, lane0 R=1 G=F B=7 → sdo[0] sampled at cko rises is 0001_1111_0111. There are 12 cko rises, busy lasts 52 cycles, lat_o is high for 4 cycles, and done pulses once at start+53.
- Same stimulus with msb_first=0 → sdo[0] sequence is 1110_1111_1000. Lane 7 (R=8 G=1 B=3) gives 1100_1000_0001.
- start pulsed twice mid-frame, inputs changed → exactly one back-to-back frame with no idle gap. It carries the inputs present in the transition cycle, and done pulses once per frame.
- en dropped at bit 5 → next cycle all outputs are 0 and there is no done pulse. start with en=0 afterwards produces no activity. After en=1 and start, a clean full frame follows.
- rstn=0 for one cycle during LATCH → all outputs 0 next cycle and pend cleared. A queued start does not fire.
- DIV=1, CW=1, CH=1 corner → cko_o toggles every cycle, busy=6+LAT_CYC cycles, and bit order is R,G,B.
